// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                controller: FSM state encoding, instruction size in bytes
//                and the default reset vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // IDLE  : no request outstanding
    // FETCH : request outstanding, returned data is kept
    // DRAIN : request outstanding, returned data is discarded
    // HALT  : terminal state after a misaligned redirect (PC_ALIGN_CHECK_EN)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int          INST_BYTES           = 4;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'd0;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Bundle of the fetch controller's pipeline-side and
//                instruction-memory-side signals.
//    Pipeline : stall, redirect, redirect_pc (in)
//               inst_valid, inst, inst_pc, misalign_fault (out)
//    Memory   : imem_req, imem_addr (out); imem_ack, imem_rdata (in)
//  Modports    : master - the fetch controller
//                slave  - the surrounding pipeline / memory model
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              misalign_fault;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_fault
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_fault
    );
endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : 2-entry FIFO of {instruction, pc}. Entry 0 is always the
//                head so the outputs come straight from flops.
//  Ports       : clk, reset (async, active-high)
//                i_push/i_inst/i_pc - enqueue
//                i_pop              - dequeue head (only while o_valid)
//                i_flush            - empty the queue (wins over push/pop)
//                o_valid/o_inst/o_pc - head entry
//                o_count_next       - occupancy after this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [INST_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic [1:0]        o_count_next
);

    logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]        count_q, count_d;
    logic              valid_q;

    always_comb begin
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        count_d = count_q;
        if (i_flush) begin
            count_d = 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    // The controller never pushes into a full queue; the
                    // guard keeps the count from wrapping regardless.
                    if (count_q == 2'd0) begin
                        inst0_d = i_inst;
                        pc0_d   = i_pc;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        inst1_d = i_inst;
                        pc1_d   = i_pc;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    inst0_d = inst1_q;
                    pc0_d   = pc1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push: occupancy unchanged.
                    if (count_q == 2'd2) begin
                        inst0_d = inst1_q;
                        pc0_d   = pc1_q;
                        inst1_d = i_inst;
                        pc1_d   = i_pc;
                    end else begin
                        inst0_d = i_inst;
                        pc0_d   = i_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst0_q <= '0;
            inst1_q <= '0;
            pc0_q   <= '0;
            pc1_q   <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
        end
    end

    assign o_valid      = valid_q;
    assign o_inst       = inst0_q;
    assign o_pc         = pc0_q;
    assign o_count_next = count_d;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch controller. Sequences the PC, keeps at
//                most one req/ack fetch outstanding and buffers returned
//                instructions in a 2-entry queue for IF/ID. Handles stalls
//                and branch/jump redirects, including redirects that land
//                while a fetch is in flight (the in-flight data is drained).
//  Ports       : clk, reset (async, active-high)
//                bus (fetch_ctrl_if.master) - pipeline and imem signals
//  Options     : PC_ALIGN_CHECK_EN - a redirect to a non-word-aligned target
//                raises a sticky misalign_fault and halts fetching once any
//                outstanding request has drained. Undefined: fault tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = 64,
    parameter int                INST_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] c_pc_inc = ADDR_W'(INST_BYTES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              imem_req_q;

    logic              w_push, w_pop, w_flush;
    logic              w_valid;
    logic              w_busy, w_still_busy;
    logic [1:0]        w_count_next;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_fault_q, misalign_fault_d;

    always_comb begin
        misalign_fault_d = misalign_fault_q;
        if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
            misalign_fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_fault_q <= 1'b0;
        end else begin
            misalign_fault_q <= misalign_fault_d;
        end
    end

    assign bus.misalign_fault = misalign_fault_q;
`else
    assign bus.misalign_fault = 1'b0;
`endif

    // Queue control. Redirect overrides both enqueue and dequeue.
    assign w_flush = bus.redirect;
    assign w_push  = bus.imem_ack && (state_q == FETCH) && !bus.redirect;
    assign w_pop   = w_valid && !bus.stall && !bus.redirect;

    // A request is still outstanding after this edge if one is in flight
    // and its ack does not arrive now.
    assign w_busy       = (state_q == FETCH) || (state_q == DRAIN);
    assign w_still_busy = w_busy && !bus.imem_ack;

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .i_inst       (bus.imem_rdata),
        .i_pc         (req_addr_q),
        .o_valid      (w_valid),
        .o_inst       (bus.inst),
        .o_pc         (bus.inst_pc),
        .o_count_next (w_count_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            HALT: ;
            default: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                    if (w_still_busy) begin
                        // Let the in-flight fetch finish, then discard it.
                        state_d = DRAIN;
`ifdef PC_ALIGN_CHECK_EN
                    end else if (misalign_fault_d) begin
                        state_d = HALT;
`endif
                    end else begin
                        // Queue is flushed, so there is always room.
                        state_d    = FETCH;
                        req_addr_d = bus.redirect_pc;
                        pc_d       = bus.redirect_pc + c_pc_inc;
                    end
                end else if (!w_still_busy) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (misalign_fault_d) begin
                        state_d = HALT;
                    end else
`endif
                    if (w_count_next != 2'd2) begin
                        state_d    = FETCH;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + c_pc_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            imem_req_q <= (state_d == FETCH) || (state_d == DRAIN);
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = req_addr_q;
    assign bus.inst_valid = w_valid;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Directed self-checking bench for fetch_ctrl. Memory returns
//                a fixed function of the fetch address so every instruction
//                can be tied back to its PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(64), .INST_W(32)) bus ();

    fetch_ctrl #(
        .ADDR_W       (64),
        .INST_W       (32),
        .RESET_VECTOR (64'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ack    = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rst_req",   bus.imem_req,       0);
        check("rst_valid", bus.inst_valid,     0);
        check("rst_inst",  bus.inst,           0);
        check("rst_pc",    bus.inst_pc,        0);
        check("rst_fault", bus.misalign_fault, 0);

        // ---- streaming with zero-wait memory ----
        reset        = 1'b0;
        bus.imem_ack = 1'b1;
        step();
        check("s_req0",   bus.imem_req,   1);
        check("s_addr0",  bus.imem_addr,  64'h0);
        check("s_valid0", bus.inst_valid, 0);
        step();
        check("s_addr1",  bus.imem_addr,  64'h4);
        check("s_valid1", bus.inst_valid, 1);
        check("s_ipc1",   bus.inst_pc,    64'h0);
        check("s_inst1",  bus.inst,       mem_word(64'h0));
        step();
        check("s_addr2",  bus.imem_addr,  64'h8);
        check("s_ipc2",   bus.inst_pc,    64'h4);

        // ---- stall: queue fills, requests stop, order preserved ----
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("st_req",   bus.imem_req,   0);
            check("st_valid", bus.inst_valid, 1);
            check("st_ipc",   bus.inst_pc,    64'h4);
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rl_valid", bus.inst_valid, 1);
            check("rl_ipc",   bus.inst_pc,    64'(8 + 4 * i));
        end

        // ---- redirect while a fetch is outstanding -> DRAIN ----
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        step();
        reset = 1'b0;
        bus.imem_ack = 1'b1;
        step();
        step();
        step();
        check("d_addr", bus.imem_addr, 64'h8);
        check("d_ipc",  bus.inst_pc,   64'h4);
        bus.imem_ack    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h1000;
        step();
        bus.redirect = 1'b0;
        check("d_req",   bus.imem_req,   1);
        check("d_hold",  bus.imem_addr,  64'h8);
        check("d_flush", bus.inst_valid, 0);
        step();
        step();
        check("d_hold2",  bus.imem_addr,  64'h8);
        check("d_valid2", bus.inst_valid, 0);
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        check("d_newaddr", bus.imem_addr,  64'h1000);
        check("d_drop",    bus.inst_valid, 0);
        step();
        check("d_wait", bus.inst_valid, 0);
        bus.imem_ack = 1'b1;
        step();
        check("d_valid", bus.inst_valid, 1);
        check("d_ipc2",  bus.inst_pc,    64'h1000);
        check("d_inst",  bus.inst,       mem_word(64'h1000));

        // ---- redirect coincident with ack ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h2000;
        step();
        bus.redirect = 1'b0;
        check("ra_addr",  bus.imem_addr,  64'h2000);
        check("ra_valid", bus.inst_valid, 0);
        step();
        check("ra_valid2", bus.inst_valid, 1);
        check("ra_ipc",    bus.inst_pc,    64'h2000);

        // ---- reset mid-request, stale ack afterwards ----
        bus.imem_ack = 1'b0;
        step();
        check("rm_req_pre", bus.imem_req, 1);
        reset = 1'b1;
        #1;
        check("rm_req",   bus.imem_req,   0);
        check("rm_valid", bus.inst_valid, 0);
        check("rm_ipc",   bus.inst_pc,    0);
        bus.imem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rm_addr",  bus.imem_addr,  64'h0);
        check("rm_stale", bus.inst_valid, 0);
        step();
        check("rm_ipc2",  bus.inst_pc,    64'h0);

        // ---- PC wrap at all-ones ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        check("w_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("w_wrap", bus.imem_addr, 64'h0);
        check("w_ipc",  bus.inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("w_ipc2", bus.inst_pc,   64'h0);

        // ---- misaligned redirect ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h1002;
        step();
        bus.redirect = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check("m_fault", bus.misalign_fault, 1);
        check("m_req",   bus.imem_req,       0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("m_sticky", bus.misalign_fault, 1);
            check("m_halt",   bus.imem_req,       0);
            check("m_empty",  bus.inst_valid,     0);
        end
`else
        check("m_nofault", bus.misalign_fault, 0);
        check("m_addr",    bus.imem_addr,      64'h1002);
        step();
        check("m_ipc",     bus.inst_pc,        64'h1002);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
